hazard_unit: RTL



---
 rtl/hazard_unit_pkg.sv | 60 ++++++
 rtl/hazard_unit_mc_busy_counter.sv | 61 ++++++
 rtl/hazard_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared decode constants, enums and register-field helpers for the hazard unit.
package hazard_unit_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return ir[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic writes_rd(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                               OPC_JAL, OPC_JALR, OPC_LOAD};
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
                               OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ir);
        return ir[6:0] inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic is_load(input logic [31:0] ir);
        return ir[6:0] == OPC_LOAD;
    endfunction

    function automatic logic is_muldiv(input logic [31:0] ir);
        return (ir[6:0] == OPC_OP) && (ir[31:25] == F7_MULDIV);
    endfunction

endpackage

// File: rtl/hazard_unit_mc_busy_counter.sv
// Tracks EX occupancy of a multi-cycle MUL/DIV op and raises mc_stall while it lasts.
module mc_busy_counter
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic start_i,
    output logic mc_stall_o
);

    localparam int unsigned CW       = $clog2(MC_LAT) + 1;
    localparam bit          MC_EN    = (MC_LAT > 1);
    localparam int unsigned CNT_INIT = (MC_LAT > 1) ? (MC_LAT - 2) : 0;

    hz_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // The entry cycle in RUN is itself the first stalled cycle, hence MC_LAT-2.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_o = 1'b0;
        if (flush_i) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (start_i && MC_EN) begin
                        mc_stall_o = 1'b1;
                        state_d    = MC_BUSY;
                        cnt_d      = CW'(CNT_INIT);
                    end
                end
                MC_BUSY: begin
                    if (cnt_q != '0) begin
                        mc_stall_o = 1'b1;
                        cnt_d      = cnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard resolution for the 5-stage pipeline: operand bypass selection,
// load-use bubbles and multi-cycle MUL/DIV front-end stalls.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned MC_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [31:0]     if_id_ir,
    input  logic [31:0]     id_ex_ir,
    input  logic [31:0]     ex_mem_ir,
    input  logic [31:0]     mem_wb_ir,
    input  logic [XLEN-1:0] ex_mem_result,
    input  logic [XLEN-1:0] mem_wb_result,
    output logic [1:0]      fwd_sel_1,
    output logic [1:0]      fwd_sel_2,
    output logic [XLEN-1:0] fwd_1,
    output logic [XLEN-1:0] fwd_2,
    output logic            fwd_en,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            bubble_ex,
    output logic            bubble_mem,
    output logic [31:0]     stall_cycles
);

    fwd_sel_e    sel1, sel2;
    logic        ex_fwd_ok, wb_fwd_ok;
    logic [4:0]  ex_rd, wb_rd, ld_rd;
    logic        load_use, mc_stall, stall_front;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        unused_ir_bits;

    assign unused_ir_bits = ^{if_id_ir, id_ex_ir, ex_mem_ir, mem_wb_ir};

    assign ex_rd = rd_of(ex_mem_ir);
    assign wb_rd = rd_of(mem_wb_ir);
    assign ld_rd = rd_of(id_ex_ir);

    // Load data is not yet available in EX/MEM; only MEM/WB may bypass it.
    assign ex_fwd_ok = writes_rd(ex_mem_ir) && (ex_rd != '0) && !is_load(ex_mem_ir);
    assign wb_fwd_ok = writes_rd(mem_wb_ir) && (wb_rd != '0);

    always_comb begin
        sel1 = FWD_NONE;
        if (ex_fwd_ok && (ex_rd == rs1_of(id_ex_ir)))      sel1 = FWD_EXMEM;
        else if (wb_fwd_ok && (wb_rd == rs1_of(id_ex_ir))) sel1 = FWD_MEMWB;

        sel2 = FWD_NONE;
        if (ex_fwd_ok && (ex_rd == rs2_of(id_ex_ir)))      sel2 = FWD_EXMEM;
        else if (wb_fwd_ok && (wb_rd == rs2_of(id_ex_ir))) sel2 = FWD_MEMWB;
    end

    always_comb begin
        fwd_1 = '0;
        fwd_2 = '0;
        case (sel1)
            FWD_EXMEM: fwd_1 = ex_mem_result;
            FWD_MEMWB: fwd_1 = mem_wb_result;
            default:   fwd_1 = '0;
        endcase
        case (sel2)
            FWD_EXMEM: fwd_2 = ex_mem_result;
            FWD_MEMWB: fwd_2 = mem_wb_result;
            default:   fwd_2 = '0;
        endcase
    end

    assign fwd_sel_1 = sel1;
    assign fwd_sel_2 = sel2;
    assign fwd_en    = (sel1 != FWD_NONE) || (sel2 != FWD_NONE);

    assign load_use = is_load(id_ex_ir) && (ld_rd != '0) &&
                      ((reads_rs1(if_id_ir) && (ld_rd == rs1_of(if_id_ir))) ||
                       (reads_rs2(if_id_ir) && (ld_rd == rs2_of(if_id_ir))));

    mc_busy_counter #(
        .MC_LAT (MC_LAT)
    ) u_mc (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .start_i    (is_muldiv(id_ex_ir)),
        .mc_stall_o (mc_stall)
    );

    // A flush kills IF/ID and ID/EX, so any pending hazard is moot that cycle.
    assign stall_front = !flush && (mc_stall || load_use);
    assign stall_if    = stall_front;
    assign stall_id    = stall_front;
    assign stall_ex    = !flush && mc_stall;
    assign bubble_mem  = !flush && mc_stall;
    assign bubble_ex   = !flush && load_use && !mc_stall;

    assign stall_cycles_d = (stall_if && (stall_cycles_q != '1)) ? stall_cycles_q + 32'd1
                                                                 : stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule
